lpddr2_avm_arbiter: RTL

- Two-requester Avalon-MM arbiter sharing the single LPDDR2 MPFE port, all in the avm_clk domain.
- Requesters are the CPU bus bridge (m0) and the DMA/video engine (m1).
- Round-robin grant; write bursts are locked to completion; pipelined read data is routed back to its owner through an owner queue.
- Gates all traffic until the memory interface reports ready (MPFE out of reset, calibration passed).

---
 rtl/lpddr2_arb_pkg.sv | 19 +
 rtl/lpddr2_arb_rdq.sv | 48 ++++
 rtl/lpddr2_avm_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/lpddr2_arb_pkg.sv
// lpddr2_arb_pkg: shared types for the LPDDR2 Avalon-MM arbiter and its read owner queue.
package lpddr2_arb_pkg;
    localparam int NUM_REQ = 2;
    // Owner-queue burst field width; must be at least the arbiter's BURST_W.
    localparam int BC_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        WBURST = 2'd2
    } state_t;

    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

    typedef struct packed {
        req_id_t         id;
        logic [BC_W-1:0] burstcount;
    } rdq_entry_t;
endpackage

// File: rtl/lpddr2_arb_rdq.sv
// lpddr2_arb_rdq: FIFO of accepted read commands; the head entry pops on the last returned beat of its burst.
module lpddr2_arb_rdq
    import lpddr2_arb_pkg::*;
#(
    parameter int MAX_PEND = 8
) (
    input  logic       avm_clk,
    input  logic       rst_n,
    input  logic       push,
    input  rdq_entry_t entry,
    input  logic       beat,
    output logic       full,
    output logic       empty,
    output req_id_t    head_id
);
    localparam int PW = $clog2(MAX_PEND);

    rdq_entry_t      mem [MAX_PEND];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [BC_W-1:0] beat_cnt;
    logic            pop;

    assign empty   = count == '0;
    assign full    = count == (PW+1)'(MAX_PEND);
    assign head_id = mem[rd_ptr].id;
    // beat_cnt holds the beats already returned for the head entry
    assign pop     = beat & ~empty & (beat_cnt == mem[rd_ptr].burstcount - BC_W'(1));

    always_ff @(posedge avm_clk) begin
        if (push)
            mem[wr_ptr] <= entry;
    end

    always_ff @(posedge avm_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
        end else begin
            wr_ptr   <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count    <= count + (PW+1)'(push) - (PW+1)'(pop);
            beat_cnt <= pop ? '0 : (beat & ~empty) ? beat_cnt + BC_W'(1) : beat_cnt;
        end
    end
endmodule

// File: rtl/lpddr2_avm_arbiter.sv
// lpddr2_avm_arbiter: round-robin arbiter of two Avalon-MM requesters onto the LPDDR2 MPFE port,
// with write bursts locked to completion and read data routed back through an owner queue.
module lpddr2_avm_arbiter
    import lpddr2_arb_pkg::*;
#(
    parameter int ADDR_W   = 27,
    parameter int DATA_W   = 32,
    parameter int BURST_W  = 4,
    parameter int MAX_PEND = 8
) (
    input  logic                avm_clk,
    input  logic                rst_n,
    input  logic                mem_ready,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [BURST_W-1:0]  m0_burstcount,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [BURST_W-1:0]  m1_burstcount,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    output logic [BURST_W-1:0]  s_burstcount,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    output logic                err_orphan
);
    state_t             state;
    req_id_t            grant, next_grant;
    logic [BURST_W-1:0] beats_left, burst_len;
    logic               req0, req1, in_cmd, g_read, g_write, wait_g, push, wr_accept;
    logic               q_full, q_empty;
    req_id_t            q_head_id;
    rdq_entry_t         q_entry;

    assign req0       = m0_read | m0_write;
    assign req1       = m1_read | m1_write;
    // grant doubles as last_grant: it only steers the mux outside IDLE
    assign next_grant = (req0 & req1) ? ~grant : req1;
    assign in_cmd     = state == CMD && mem_ready;

    assign g_read       = grant ? m1_read : m0_read;
    assign g_write      = grant ? m1_write : m0_write;
    assign s_address    = grant ? m1_address : m0_address;
    assign s_writedata  = grant ? m1_writedata : m0_writedata;
    assign s_byteenable = grant ? m1_byteenable : m0_byteenable;
    assign s_burstcount = grant ? m1_burstcount : m0_burstcount;
    assign burst_len    = s_burstcount == '0 ? BURST_W'(1) : s_burstcount;

    assign s_read    = in_cmd & g_read & ~q_full;
    assign s_write   = g_write & ((in_cmd & ~g_read) | (state == WBURST));
    assign wait_g    = ~(s_read | s_write) | s_waitrequest;
    assign push      = s_read & ~s_waitrequest;
    assign wr_accept = s_write & ~s_waitrequest;

    assign m0_waitrequest = grant | wait_g;
    assign m1_waitrequest = ~grant | wait_g;

    assign q_entry          = '{id: grant, burstcount: BC_W'(burst_len)};
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = s_readdatavalid & ~q_empty & ~q_head_id;
    assign m1_readdatavalid = s_readdatavalid & ~q_empty & q_head_id;

    lpddr2_arb_rdq #(.MAX_PEND(MAX_PEND)) u_rdq (
        .avm_clk (avm_clk),
        .rst_n   (rst_n),
        .push    (push),
        .entry   (q_entry),
        .beat    (s_readdatavalid),
        .full    (q_full),
        .empty   (q_empty),
        .head_id (q_head_id)
    );

    always_ff @(posedge avm_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b1;
            beats_left <= '0;
            err_orphan <= 1'b0;
        end else begin
            err_orphan <= err_orphan | (s_readdatavalid & q_empty);
            case (state)
                IDLE: if (mem_ready & (req0 | req1)) begin
                    state <= CMD;
                    grant <= next_grant;
                end
                CMD: if (push) begin
                    state <= IDLE;
                end else if (wr_accept) begin
                    state      <= burst_len > BURST_W'(1) ? WBURST : IDLE;
                    beats_left <= burst_len - BURST_W'(1);
                end
                WBURST: if (wr_accept) begin
                    beats_left <= beats_left - BURST_W'(1);
                    if (beats_left == BURST_W'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
